// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle MIPS control sequencer (FETCH/DECODE/EXEC/MEM/WB)
//   in : clk, rst (sync, active-high), op/func (IR fields), zero (ALU Z), mem_ready
//   out: state, pc_write/pc_src, ir_write, mem_req/mem_we/iord, alu_src_b/aluc/shift/sext,
//        reg_write/reg_dst/mem_to_reg, mem_size/unsign, illegal (sticky), retired count
module multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       op,
    input  logic [5:0]       func,
    input  logic             zero,
    input  logic             mem_ready,
    output logic [2:0]       state,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             ir_write,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             alu_src_b,
    output logic [3:0]       aluc,
    output logic             shift,
    output logic             sext,
    output logic             reg_write,
    output logic [1:0]       reg_dst,
    output logic [1:0]       mem_to_reg,
    output logic [1:0]       mem_size,
    output logic             unsign,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);
    localparam logic [3:0] ALUOp_ADDU = 4'd0, ALUOp_ADD = 4'd1, ALUOp_SUB = 4'd2, ALUOp_SUBU = 4'd3,
                           ALUOp_AND = 4'd4, ALUOp_OR = 4'd5, ALUOp_XOR = 4'd6, ALUOp_NOR = 4'd7,
                           ALUOp_SLT = 4'd8, ALUOp_SLTU = 4'd9, ALUOp_SLL = 4'd10, ALUOp_SRL = 4'd11,
                           ALUOp_SRA = 4'd12, ALUOp_LUI = 4'd13, ALUOp_EQL = 4'd14, ALUOp_BNE = 4'd15;
    typedef enum logic [2:0] {
        S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3, S_WB = 3'd4, S_ILLEGAL = 3'd7
    } state_t;
    state_t state_q, state_d;
    logic illegal_q;
    logic [CNT_W-1:0] retired_q;
    logic r_type, is_j, is_jal, is_jr, jump, is_br, is_load, is_store, imm_s, imm_z;
    logic is_shift, r_alu, known, ls_byte, ls_half;
    logic run, s_f, s_d, s_e, s_m, s_w;
    logic [3:0] alu_op;
    always_comb begin
        r_type   = op == 6'h00;
        is_j     = op == 6'h02;
        is_jal   = op == 6'h03;
        is_jr    = r_type && func == 6'h08;
        jump     = is_j || is_jal || is_jr;
        is_br    = op == 6'h04 || op == 6'h05;
        is_load  = op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
        is_store = op inside {6'h28, 6'h29, 6'h2B};
        imm_s    = op inside {6'h08, 6'h09, 6'h0A, 6'h0B};
        imm_z    = op inside {6'h0C, 6'h0D, 6'h0E, 6'h0F};
        is_shift = r_type && func inside {6'h00, 6'h02, 6'h03};
        r_alu    = is_shift || (r_type && func inside {[6'h20:6'h27], 6'h2A, 6'h2B});
        known    = jump || is_br || is_load || is_store || imm_s || imm_z || r_alu;
        ls_byte  = op inside {6'h20, 6'h24, 6'h28};
        ls_half  = op inside {6'h21, 6'h25, 6'h29};
    end
    always_comb begin
        alu_op = ALUOp_ADDU;
        if (r_type)
            case (func)
                6'h00:   alu_op = ALUOp_SLL;
                6'h02:   alu_op = ALUOp_SRL;
                6'h03:   alu_op = ALUOp_SRA;
                6'h20:   alu_op = ALUOp_ADD;
                6'h21:   alu_op = ALUOp_ADDU;
                6'h22:   alu_op = ALUOp_SUB;
                6'h23:   alu_op = ALUOp_SUBU;
                6'h24:   alu_op = ALUOp_AND;
                6'h25:   alu_op = ALUOp_OR;
                6'h26:   alu_op = ALUOp_XOR;
                6'h27:   alu_op = ALUOp_NOR;
                6'h2A:   alu_op = ALUOp_SLT;
                6'h2B:   alu_op = ALUOp_SLTU;
                default: alu_op = ALUOp_ADDU;
            endcase
        else
            case (op)
                6'h04:   alu_op = ALUOp_EQL;
                6'h05:   alu_op = ALUOp_BNE;
                6'h08:   alu_op = ALUOp_ADD;
                6'h09:   alu_op = ALUOp_ADDU;
                6'h0A:   alu_op = ALUOp_SLT;
                6'h0B:   alu_op = ALUOp_SLTU;
                6'h0C:   alu_op = ALUOp_AND;
                6'h0D:   alu_op = ALUOp_OR;
                6'h0E:   alu_op = ALUOp_XOR;
                6'h0F:   alu_op = ALUOp_LUI;
                default: alu_op = (is_load || is_store) ? ALUOp_ADD : ALUOp_ADDU;
            endcase
    end
    always_comb begin
        case (state_q)
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: state_d = jump ? S_FETCH : known ? S_EXEC : S_ILLEGAL;
            S_EXEC:   state_d = is_br ? S_FETCH : (is_load || is_store) ? S_MEM : S_WB;
            S_MEM:    state_d = !mem_ready ? S_MEM : is_load ? S_WB : S_FETCH;
            S_WB:     state_d = S_FETCH;
            default:  state_d = S_ILLEGAL;
        endcase
    end
    // Every output is gated by !rst so an aborted instruction cannot issue a write.
    assign run        = !rst;
    assign s_f        = run && state_q == S_FETCH;
    assign s_d        = run && state_q == S_DECODE;
    assign s_e        = run && state_q == S_EXEC;
    assign s_m        = run && state_q == S_MEM;
    assign s_w        = run && state_q == S_WB;
    assign state      = run ? state_q : 3'd0;
    assign pc_write   = (s_f && mem_ready) || (s_d && jump) || (s_e && is_br && zero);
    assign pc_src     = (s_d && is_jr) ? 2'b11 : (s_d && jump) ? 2'b10 : (s_e && is_br && zero) ? 2'b01 : 2'b00;
    assign ir_write   = s_f && mem_ready;
    assign mem_req    = s_f || s_m;
    assign mem_we     = s_m && is_store;
    assign iord       = s_m;
    assign alu_src_b  = s_e && (imm_s || imm_z || is_load || is_store);
    assign shift      = s_e && is_shift;
    assign sext       = s_e && (imm_s || is_load || is_store);
    assign aluc       = (s_e || s_m || s_w) ? alu_op : 4'd0;
    assign reg_write  = (s_d && is_jal) || s_w;
    assign reg_dst    = (s_d && is_jal) ? 2'b10 : (s_w && r_type) ? 2'b01 : 2'b00;
    assign mem_to_reg = (s_d && is_jal) ? 2'b10 : (s_w && is_load) ? 2'b01 : 2'b00;
    assign mem_size   = !s_m ? 2'b00 : ls_byte ? 2'b10 : ls_half ? 2'b01 : 2'b00;
    assign unsign     = s_m && (op == 6'h24 || op == 6'h25);
    assign illegal    = run && illegal_q;
    assign retired    = run ? retired_q : '0;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_q || state_d == S_ILLEGAL;
            retired_q <= retired_q + CNT_W'(state_q != S_FETCH && state_d == S_FETCH);
        end
    end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: scoreboard bench for multicycle_ctrl
module tb_multicycle_ctrl;
    logic clk = 1'b0, rst = 1'b1, zero = 1'b0, mem_ready = 1'b0;
    logic [5:0] op = 6'h00, func = 6'h00;
    logic [2:0] state;
    logic pc_write, ir_write, mem_req, mem_we, iord, alu_src_b, shift, sext, reg_write, unsign, illegal;
    logic [1:0] pc_src, reg_dst, mem_to_reg, mem_size;
    logic [3:0] aluc;
    logic [31:0] retired;
    typedef struct packed {
        logic [2:0]  state;
        logic        pc_write;
        logic [1:0]  pc_src;
        logic        ir_write, mem_req, mem_we, iord, alu_src_b;
        logic [3:0]  aluc;
        logic        shift, sext, reg_write;
        logic [1:0]  reg_dst, mem_to_reg, mem_size;
        logic        unsign, illegal;
        logic [31:0] retired;
    } exp_t;
    typedef struct {
        string name;
        exp_t  e;
    } item_t;
    item_t sb[$];
    item_t it;
    exp_t act, e;
    int r = 0, chk_cnt = 0, pass_cnt = 0;
    multicycle_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .op(op), .func(func), .zero(zero), .mem_ready(mem_ready),
        .state(state), .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write),
        .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .alu_src_b(alu_src_b), .aluc(aluc),
        .shift(shift), .sext(sext), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .mem_size(mem_size), .unsign(unsign), .illegal(illegal),
        .retired(retired)
    );
    always #5 clk = ~clk;
    assign act = {state, pc_write, pc_src, ir_write, mem_req, mem_we, iord, alu_src_b, aluc,
                  shift, sext, reg_write, reg_dst, mem_to_reg, mem_size, unsign, illegal, retired};
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            it = sb.pop_front();
            chk_cnt++;
            if (act === it.e) pass_cnt++;
            else $display("FAIL %s: got %h expected %h", it.name, act, it.e);
        end
    end
    function automatic exp_t E(input logic [2:0] st);
        exp_t x = '0;
        x.state = st;
        x.retired = r;
        return x;
    endfunction
    task automatic cyc(input string n, input logic mr, input logic z, input exp_t x);
        mem_ready = mr;
        zero = z;
        sb.push_back('{n, x});
        @(posedge clk);
        #1;
    endtask
    task automatic ins(input logic [5:0] o, input logic [5:0] f);
        op = o;
        func = f;
    endtask
    task automatic fetch(input string n, input int waits);
        exp_t x;
        x = E(3'd0);
        x.mem_req = 1'b1;
        for (int i = 0; i < waits; i++) cyc({n, "_fwait"}, 1'b0, 1'b0, x);
        x.pc_write = 1'b1;
        x.ir_write = 1'b1;
        cyc({n, "_fetch"}, 1'b1, 1'b0, x);
    endtask
    task automatic dec(input string n);
        cyc({n, "_dec"}, 1'b1, 1'b0, E(3'd1));
    endtask
    initial begin
        @(posedge clk);
        #1;
        cyc("rst0", 1'b1, 1'b0, '0);
        cyc("rst1", 1'b1, 1'b0, '0);
        rst = 1'b0;
        // add $3,$1,$2
        ins(6'h00, 6'h20); fetch("add", 0); dec("add");
        e = E(3'd2); e.aluc = 4'd1; cyc("add_ex", 1'b1, 1'b0, e);
        e = E(3'd4); e.aluc = 4'd1; e.reg_write = 1'b1; e.reg_dst = 2'b01; cyc("add_wb", 1'b1, 1'b0, e);
        r++;
        // sll
        ins(6'h00, 6'h00); fetch("sll", 0); dec("sll");
        e = E(3'd2); e.aluc = 4'd10; e.shift = 1'b1; cyc("sll_ex", 1'b1, 1'b0, e);
        e = E(3'd4); e.aluc = 4'd10; e.reg_write = 1'b1; e.reg_dst = 2'b01; cyc("sll_wb", 1'b1, 1'b0, e);
        r++;
        // ori
        ins(6'h0D, 6'h00); fetch("ori", 0); dec("ori");
        e = E(3'd2); e.aluc = 4'd5; e.alu_src_b = 1'b1; cyc("ori_ex", 1'b1, 1'b0, e);
        e = E(3'd4); e.aluc = 4'd5; e.reg_write = 1'b1; cyc("ori_wb", 1'b1, 1'b0, e);
        r++;
        // lw with 3 fetch waits and 2 memory waits: 10 cycles
        ins(6'h23, 6'h00); fetch("lw", 3); dec("lw");
        e = E(3'd2); e.aluc = 4'd1; e.alu_src_b = 1'b1; e.sext = 1'b1; cyc("lw_ex", 1'b1, 1'b0, e);
        e = E(3'd3); e.aluc = 4'd1; e.mem_req = 1'b1; e.iord = 1'b1;
        cyc("lw_mwait0", 1'b0, 1'b0, e); cyc("lw_mwait1", 1'b0, 1'b0, e); cyc("lw_mem", 1'b1, 1'b0, e);
        e = E(3'd4); e.aluc = 4'd1; e.reg_write = 1'b1; e.mem_to_reg = 2'b01; cyc("lw_wb", 1'b1, 1'b0, e);
        r++;
        // lbu
        ins(6'h24, 6'h00); fetch("lbu", 0); dec("lbu");
        e = E(3'd2); e.aluc = 4'd1; e.alu_src_b = 1'b1; e.sext = 1'b1; cyc("lbu_ex", 1'b1, 1'b0, e);
        e = E(3'd3); e.aluc = 4'd1; e.mem_req = 1'b1; e.iord = 1'b1; e.mem_size = 2'b10; e.unsign = 1'b1;
        cyc("lbu_mem", 1'b1, 1'b0, e);
        e = E(3'd4); e.aluc = 4'd1; e.reg_write = 1'b1; e.mem_to_reg = 2'b01; cyc("lbu_wb", 1'b1, 1'b0, e);
        r++;
        // sh: 4 cycles, back to FETCH after MEM
        ins(6'h29, 6'h00); fetch("sh", 0); dec("sh");
        e = E(3'd2); e.aluc = 4'd1; e.alu_src_b = 1'b1; e.sext = 1'b1; cyc("sh_ex", 1'b1, 1'b0, e);
        e = E(3'd3); e.aluc = 4'd1; e.mem_req = 1'b1; e.iord = 1'b1; e.mem_we = 1'b1; e.mem_size = 2'b01;
        cyc("sh_mem", 1'b1, 1'b0, e);
        r++;
        // beq taken, beq not taken, bne with zero=1
        ins(6'h04, 6'h00); fetch("beq_t", 0); dec("beq_t");
        e = E(3'd2); e.aluc = 4'd14; e.pc_write = 1'b1; e.pc_src = 2'b01; cyc("beq_t_ex", 1'b1, 1'b1, e);
        r++;
        fetch("beq_n", 0); dec("beq_n");
        e = E(3'd2); e.aluc = 4'd14; cyc("beq_n_ex", 1'b1, 1'b0, e);
        r++;
        ins(6'h05, 6'h00); fetch("bne", 0); dec("bne");
        e = E(3'd2); e.aluc = 4'd15; e.pc_write = 1'b1; e.pc_src = 2'b01; cyc("bne_ex", 1'b1, 1'b1, e);
        r++;
        // jal, j, jr: 2 cycles each
        ins(6'h03, 6'h00); fetch("jal", 0);
        e = E(3'd1); e.pc_write = 1'b1; e.pc_src = 2'b10; e.reg_write = 1'b1; e.reg_dst = 2'b10;
        e.mem_to_reg = 2'b10; cyc("jal_dec", 1'b1, 1'b0, e);
        r++;
        ins(6'h02, 6'h00); fetch("j", 0);
        e = E(3'd1); e.pc_write = 1'b1; e.pc_src = 2'b10; cyc("j_dec", 1'b1, 1'b0, e);
        r++;
        ins(6'h00, 6'h08); fetch("jr", 0);
        e = E(3'd1); e.pc_write = 1'b1; e.pc_src = 2'b11; cyc("jr_dec", 1'b1, 1'b0, e);
        r++;
        // sb aborted by reset while waiting in MEM
        ins(6'h28, 6'h00); fetch("sb", 0); dec("sb");
        e = E(3'd2); e.aluc = 4'd1; e.alu_src_b = 1'b1; e.sext = 1'b1; cyc("sb_ex", 1'b1, 1'b0, e);
        e = E(3'd3); e.aluc = 4'd1; e.mem_req = 1'b1; e.iord = 1'b1; e.mem_we = 1'b1; e.mem_size = 2'b10;
        cyc("sb_mwait", 1'b0, 1'b0, e);
        rst = 1'b1;
        cyc("sb_rst0", 1'b1, 1'b0, '0);
        cyc("sb_rst1", 1'b1, 1'b0, '0);
        rst = 1'b0;
        r = 0;
        // add after reset so the illegal check sees a nonzero retired count
        ins(6'h00, 6'h20); fetch("add2", 0); dec("add2");
        e = E(3'd2); e.aluc = 4'd1; cyc("add2_ex", 1'b1, 1'b0, e);
        e = E(3'd4); e.aluc = 4'd1; e.reg_write = 1'b1; e.reg_dst = 2'b01; cyc("add2_wb", 1'b1, 1'b0, e);
        r++;
        // unknown opcode: absorbing ILLEGAL for 20 cycles
        ins(6'h3F, 6'h00); fetch("ill_op", 0); dec("ill_op");
        e = E(3'd7); e.illegal = 1'b1;
        for (int i = 0; i < 20; i++) cyc("ill_op_hold", 1'b1, 1'b1, e);
        rst = 1'b1;
        cyc("ill_rst", 1'b1, 1'b0, '0);
        rst = 1'b0;
        r = 0;
        // unknown funct with R-type op
        ins(6'h00, 6'h3F); fetch("ill_fn", 0); dec("ill_fn");
        e = E(3'd7); e.illegal = 1'b1;
        for (int i = 0; i < 3; i++) cyc("ill_fn_hold", 1'b1, 1'b0, e);
        rst = 1'b1;
        cyc("ill_fn_rst", 1'b1, 1'b0, '0);
        rst = 1'b0;
        e = E(3'd0); e.mem_req = 1'b1; cyc("post_rst_fetch", 1'b0, 1'b0, e);
        chk_cnt++;
        if (sb.size() == 0) pass_cnt++;
        else $display("FAIL drain: got %0d pending expected 0", sb.size());
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
